// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
// Module      : inst_encoder
// Description : RV32I instruction encoder. Takes decoded instruction fields
//               over a valid/ready request port and emits the packed 32-bit
//               instruction word, tagged with a sequential address, through a
//               registered valid/ready output stage. Unencodable requests
//               produce the canonical NOP with inst_err set.
//               Optional macro INST_ENC_RANGE_CHK_EN compiles in immediate
//               range/alignment checking.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_kind,
    input  logic [3:0]  req_alu_op,
    input  logic [2:0]  req_funct3,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [31:0] req_imm,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_addr,
    output logic        inst_err
);

    // Instruction kinds
    localparam logic [3:0] c_kind_lui    = 4'd0;
    localparam logic [3:0] c_kind_auipc  = 4'd1;
    localparam logic [3:0] c_kind_jal    = 4'd2;
    localparam logic [3:0] c_kind_jalr   = 4'd3;
    localparam logic [3:0] c_kind_branch = 4'd4;
    localparam logic [3:0] c_kind_load   = 4'd5;
    localparam logic [3:0] c_kind_store  = 4'd6;
    localparam logic [3:0] c_kind_op_imm = 4'd7;
    localparam logic [3:0] c_kind_op     = 4'd8;
    localparam logic [3:0] c_kind_fence  = 4'd9;
    localparam logic [3:0] c_kind_system = 4'd10;

    // Major opcodes
    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_op_imm = 7'b0010011;
    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_fence  = 7'b0001111;
    localparam logic [6:0] c_opc_system = 7'b1110011;

    localparam logic [3:0]  c_alu_sub = 4'd1;
    localparam logic [31:0] c_nop     = 32'h0000_0013;

    logic        w_accept;
    logic        w_xfer;
    logic [2:0]  w_alu_f3;
    logic [6:0]  w_alu_f7;
    logic        w_alu_bad;
    logic        w_is_shift;
    logic [31:0] w_inst;
    logic        w_ill;
    logic        w_rng_bad;
    logic        w_err;
    logic [31:0] w_enc;

    logic        r_valid;
    logic [31:0] r_inst;
    logic [31:0] r_inst_addr;
    logic        r_err;
    logic [31:0] r_addr;

    assign req_ready  = !r_valid || inst_ready;
    assign w_accept   = req_valid && req_ready;
    assign w_xfer     = r_valid && inst_ready;

    assign inst_valid = r_valid;
    assign inst       = r_inst;
    assign inst_addr  = r_inst_addr;
    assign inst_err   = r_err;

    // ALU op to funct3/funct7 mapping shared by OP and OP_IMM
    always_comb begin
        w_alu_f3   = 3'b000;
        w_alu_f7   = 7'b0000000;
        w_alu_bad  = 1'b0;
        w_is_shift = 1'b0;
        case (req_alu_op)
            4'd0: w_alu_f3 = 3'b000;                               // ADD
            4'd1: begin w_alu_f3 = 3'b000; w_alu_f7 = 7'b0100000; end // SUB
            4'd2: w_alu_f3 = 3'b111;                               // AND
            4'd3: w_alu_f3 = 3'b110;                               // OR
            4'd4: w_alu_f3 = 3'b100;                               // XOR
            4'd5: w_alu_f3 = 3'b010;                               // SLT
            4'd6: w_alu_f3 = 3'b011;                               // SLTU
            4'd7: begin w_alu_f3 = 3'b001; w_is_shift = 1'b1; end    // SLL
            4'd8: begin w_alu_f3 = 3'b101; w_is_shift = 1'b1; end    // SRL
            4'd9: begin                                            // SRA
                w_alu_f3   = 3'b101;
                w_alu_f7   = 7'b0100000;
                w_is_shift = 1'b1;
            end
            default: w_alu_bad = 1'b1;
        endcase
    end

    // Field packing per instruction format, flagging always-illegal requests
    always_comb begin
        w_inst = c_nop;
        w_ill  = 1'b0;
        case (req_kind)
            c_kind_lui:   w_inst = {req_imm[31:12], req_rd, c_opc_lui};
            c_kind_auipc: w_inst = {req_imm[31:12], req_rd, c_opc_auipc};
            c_kind_jal:   w_inst = {req_imm[20], req_imm[10:1], req_imm[11],
                                    req_imm[19:12], req_rd, c_opc_jal};
            c_kind_jalr: begin
                w_inst = {req_imm[11:0], req_rs1, req_funct3, req_rd, c_opc_jalr};
                w_ill  = (req_funct3 != 3'b000);
            end
            c_kind_branch: begin
                w_inst = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                          req_imm[4:1], req_imm[11], c_opc_branch};
                w_ill  = (req_funct3 == 3'b010) || (req_funct3 == 3'b011) ||
                         (req_funct3 == 3'b110);
            end
            c_kind_load:  w_inst = {req_imm[11:0], req_rs1, req_funct3, req_rd, c_opc_load};
            c_kind_store: w_inst = {req_imm[11:5], req_rs2, req_rs1, req_funct3,
                                    req_imm[4:0], c_opc_store};
            c_kind_op_imm: begin
                w_ill = w_alu_bad || (req_alu_op == c_alu_sub);
                if (w_is_shift) begin
                    w_inst = {w_alu_f7, req_imm[4:0], req_rs1, w_alu_f3, req_rd, c_opc_op_imm};
                end else begin
                    w_inst = {req_imm[11:0], req_rs1, w_alu_f3, req_rd, c_opc_op_imm};
                end
            end
            c_kind_op: begin
                w_ill  = w_alu_bad;
                w_inst = {w_alu_f7, req_rs2, req_rs1, w_alu_f3, req_rd, c_opc_op};
            end
            c_kind_fence:  w_inst = {req_imm[11:0], req_rs1, req_funct3, req_rd, c_opc_fence};
            c_kind_system: w_inst = {req_imm[11:0], req_rs1, req_funct3, req_rd, c_opc_system};
            default:       w_ill  = 1'b1;
        endcase
    end

`ifdef INST_ENC_RANGE_CHK_EN
    logic w_i_ok;
    logic w_b_ok;
    logic w_j_ok;
    logic w_u_ok;
    logic w_sh_ok;

    // Sign-extension means every bit above the field's top bit equals it
    assign w_i_ok  = (&req_imm[31:11]) || !(|req_imm[31:11]);
    assign w_b_ok  = ((&req_imm[31:12]) || !(|req_imm[31:12])) && !req_imm[0];
    assign w_j_ok  = ((&req_imm[31:20]) || !(|req_imm[31:20])) && !req_imm[0];
    assign w_u_ok  = (req_imm[11:0] == 12'd0);
    assign w_sh_ok = (req_imm[31:5] == 27'd0);

    // Immediate range/alignment check selected by instruction format
    always_comb begin
        w_rng_bad = 1'b0;
        case (req_kind)
            c_kind_lui, c_kind_auipc: w_rng_bad = !w_u_ok;
            c_kind_jal:               w_rng_bad = !w_j_ok;
            c_kind_branch:            w_rng_bad = !w_b_ok;
            c_kind_jalr, c_kind_load, c_kind_store, c_kind_fence, c_kind_system:
                                      w_rng_bad = !w_i_ok;
            c_kind_op_imm:            w_rng_bad = w_is_shift ? !w_sh_ok : !w_i_ok;
            default:                  w_rng_bad = 1'b0;
        endcase
    end
`else
    // Immediates are truncated to their encodable bits; no range errors
    assign w_rng_bad = 1'b0;
`endif

    assign w_err = w_ill || w_rng_bad;
    assign w_enc = w_err ? c_nop : w_inst;

    // Output register and address counter; a new word loaded in the same
    // cycle as a transfer carries the already-advanced address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_inst      <= c_nop;
            r_inst_addr <= BASE_ADDR;
            r_err       <= 1'b0;
            r_addr      <= BASE_ADDR;
        end else begin
            if (w_xfer) begin
                r_addr <= r_addr + 32'd4;
            end
            if (w_accept) begin
                r_valid     <= 1'b1;
                r_inst      <= w_enc;
                r_err       <= w_err;
                r_inst_addr <= w_xfer ? (r_addr + 32'd4) : r_addr;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_encoder
// Description : Directed self-checking bench for inst_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_encoder;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_kind;
    logic [3:0]  req_alu_op;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [31:0] req_imm;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        inst_err;

    logic        wrap_req_ready;
    logic        wrap_inst_valid;
    logic [31:0] wrap_inst;
    logic [31:0] wrap_inst_addr;
    logic        wrap_inst_err;

    int total;
    int bad;

    inst_encoder u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_kind   (req_kind),
        .req_alu_op (req_alu_op),
        .req_funct3 (req_funct3),
        .req_rd     (req_rd),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_imm    (req_imm),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_addr  (inst_addr),
        .inst_err   (inst_err)
    );

    // Second instance starting at the top of the address space
    inst_encoder #(.BASE_ADDR(32'hFFFF_FFFC)) u_wrap (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (wrap_req_ready),
        .req_kind   (req_kind),
        .req_alu_op (req_alu_op),
        .req_funct3 (req_funct3),
        .req_rd     (req_rd),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_imm    (req_imm),
        .inst_valid (wrap_inst_valid),
        .inst_ready (inst_ready),
        .inst       (wrap_inst),
        .inst_addr  (wrap_inst_addr),
        .inst_err   (wrap_inst_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] kind, input logic [3:0] alu, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
        req_valid  = 1'b1;
        req_kind   = kind;
        req_alu_op = alu;
        req_funct3 = f3;
        req_rd     = rd;
        req_rs1    = rs1;
        req_rs2    = rs2;
        req_imm    = imm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        req_valid = 1'b0; req_kind = '0; req_alu_op = '0; req_funct3 = '0;
        req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
        inst_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst",  inst, 32'h0000_0013);
        chk("rst_addr",  inst_addr, 32'h8000_0000);
        chk("rst_err",   {31'd0, inst_err}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        rst = 1'b0;

        // ADDI x1,x0,5
        drive(4'd7, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        tick();
        chk("addi_valid", {31'd0, inst_valid}, 32'd1);
        chk("addi_inst",  inst, 32'h0050_0093);
        chk("addi_addr",  inst_addr, 32'h8000_0000);
        chk("addi_err",   {31'd0, inst_err}, 32'd0);
        chk("wrap_addr0", wrap_inst_addr, 32'hFFFF_FFFC);

        // ADD x3,x1,x2 back to back
        drive(4'd8, 4'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        tick();
        chk("add_inst",  inst, 32'h0020_81B3);
        chk("add_addr",  inst_addr, 32'h8000_0004);
        chk("wrap_addr1", wrap_inst_addr, 32'h0000_0000);

        // SUB x3,x1,x2 with no bubble
        drive(4'd8, 4'd1, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        tick();
        chk("sub_valid", {31'd0, inst_valid}, 32'd1);
        chk("sub_inst",  inst, 32'h4020_81B3);
        chk("sub_addr",  inst_addr, 32'h8000_0008);

        // LUI x5,0x12345000
        drive(4'd0, 4'd0, 3'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        tick();
        chk("lui_inst", inst, 32'h1234_52B7);
        chk("lui_addr", inst_addr, 32'h8000_000C);

        // JAL x1,+8
        drive(4'd2, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd8);
        tick();
        chk("jal_inst", inst, 32'h0080_00EF);

        // BEQ x1,x2,-4
        drive(4'd4, 4'd0, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
        tick();
        chk("beq_inst", inst, 32'hFE20_8EE3);
        chk("beq_addr", inst_addr, 32'h8000_0014);
        chk("beq_err",  {31'd0, inst_err}, 32'd0);

        req_valid = 1'b0;
        tick();
        chk("drain_valid", {31'd0, inst_valid}, 32'd0);

        // Backpressure: ADDI x2,x0,1 then ADDI x3,x0,2 while consumer stalls
        inst_ready = 1'b0;
        drive(4'd7, 4'd0, 3'd0, 5'd2, 5'd0, 5'd0, 32'd1);
        tick();
        chk("bp1_inst", inst, 32'h0010_0113);
        chk("bp1_addr", inst_addr, 32'h8000_0018);
        drive(4'd7, 4'd0, 3'd0, 5'd3, 5'd0, 5'd0, 32'd2);
        chk("bp_ready_lo", {31'd0, req_ready}, 32'd0);
        tick();
        chk("bp_hold_inst", inst, 32'h0010_0113);
        chk("bp_hold_addr", inst_addr, 32'h8000_0018);
        chk("bp_hold_valid", {31'd0, inst_valid}, 32'd1);
        inst_ready = 1'b1;
        #1;
        chk("bp_ready_hi", {31'd0, req_ready}, 32'd1);
        tick();
        chk("bp2_inst", inst, 32'h0020_0193);
        chk("bp2_addr", inst_addr, 32'h8000_001C);
        req_valid = 1'b0;
        tick();
        chk("bp_drain", {31'd0, inst_valid}, 32'd0);

        // ADDI x1,x0,2048: out of range only when checking is compiled in
        drive(4'd7, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        tick();
`ifdef INST_ENC_RANGE_CHK_EN
        chk("big_inst", inst, 32'h0000_0013);
        chk("big_err",  {31'd0, inst_err}, 32'd1);
`else
        chk("big_inst", inst, 32'h8000_0093);
        chk("big_err",  {31'd0, inst_err}, 32'd0);
`endif
        chk("big_addr", inst_addr, 32'h8000_0020);

        // Illegal kind 12
        drive(4'd12, 4'd0, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        tick();
        chk("kind12_inst", inst, 32'h0000_0013);
        chk("kind12_err",  {31'd0, inst_err}, 32'd1);
        chk("kind12_addr", inst_addr, 32'h8000_0024);

        // OP_IMM with SUB is illegal
        drive(4'd7, 4'd1, 3'd0, 5'd1, 5'd2, 5'd0, 32'd1);
        tick();
        chk("subi_inst", inst, 32'h0000_0013);
        chk("subi_err",  {31'd0, inst_err}, 32'd1);

        // BRANCH funct3=010 is illegal
        drive(4'd4, 4'd0, 3'd2, 5'd0, 5'd1, 5'd2, 32'd8);
        tick();
        chk("br010_err", {31'd0, inst_err}, 32'd1);

        // JALR funct3!=000 is illegal
        drive(4'd3, 4'd0, 3'd1, 5'd1, 5'd2, 5'd0, 32'd4);
        tick();
        chk("jalr_f3_err", {31'd0, inst_err}, 32'd1);

        // OP with alu_op 10 is illegal
        drive(4'd8, 4'd10, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        tick();
        chk("alu10_err", {31'd0, inst_err}, 32'd1);

        // SRAI x1,x2,3
        drive(4'd7, 4'd9, 3'd0, 5'd1, 5'd2, 5'd0, 32'd3);
        tick();
        chk("srai_inst", inst, 32'h4031_5093);
        chk("srai_err",  {31'd0, inst_err}, 32'd0);
        chk("srai_addr", inst_addr, 32'h8000_0038);

        // SW x2,8(x1)
        drive(4'd6, 4'd0, 3'd2, 5'd0, 5'd1, 5'd2, 32'd8);
        tick();
        chk("sw_inst", inst, 32'h0020_A423);

        // Reset while a word is stalled
        inst_ready = 1'b0;
        drive(4'd7, 4'd0, 3'd0, 5'd1, 5'd0, 5'd5, 32'd5);
        tick();
        req_valid = 1'b0;
        chk("pre_rst_valid", {31'd0, inst_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("mid_rst_addr",  inst_addr, 32'h8000_0000);
        tick();
        rst = 1'b0;
        inst_ready = 1'b1;
        drive(4'd8, 4'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        tick();
        chk("post_rst_inst", inst, 32'h0020_81B3);
        chk("post_rst_addr", inst_addr, 32'h8000_0000);
        req_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_encoder.md
# inst_encoder

- Sequential RISC-V RV32I instruction encoder: the inverse of the instruction decoder.
- Accepts decoded instruction fields (instruction kind, register addresses, ALU op, funct3, full immediate) over a valid/ready request port.
- Emits the packed 32-bit instruction word, tagged with a sequential target address, through a registered valid/ready output stage.
- Used by the self-test program loader and testbench stimulus generator to write instruction memory.

## Interface
- `BASE_ADDR`, default 32'h8000_0000: address tagged on the first emitted word after reset.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request fields valid.
- `req_ready` out 1: encoder can accept a request this cycle.
- `req_kind` in 4: 0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OP_IMM, 8 OP, 9 FENCE, 10 SYSTEM, 11–15 illegal.
- `req_alu_op` in 4: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9; used only for OP and OP_IMM.
- `req_funct3` in 3: funct3 for BRANCH, LOAD, STORE, JALR, FENCE and SYSTEM.
- `req_rd`, `req_rs1`, `req_rs2` in 5 each: register addresses.
- `req_imm` in 32: architectural immediate value, sign-extended. For U-type it is the full value, with bits [11:0] expected to be 0.
- `inst_valid` out 1: output word valid.
- `inst_ready` in 1: consumer accepts the output word.
- `inst` out 32: encoded instruction.
- `inst_addr` out 32: address for `inst`.
- `inst_err` out 1: the request was unencodable; `inst` holds the canonical NOP.

## Operation
- Request handshake: a request is accepted when `req_valid && req_ready`.
- Ready rule: `req_ready = !inst_valid || inst_ready`. This gives full throughput with no bubbles.
- Acceptance: on acceptance, the encoded word, the error flag and the current address register are loaded into the output register, and `inst_valid` is set.
- Output handshake: the output transfers when `inst_valid && inst_ready`.
- Address advance: each output transfer advances the address register by 4, modulo 2^32; it wraps from 0xFFFF_FFFC to 0x0000_0000.
- Valid clear: if a transfer occurs with no new acceptance in the same cycle, `inst_valid` clears.
- Encoding per kind:
  - LUI (0110111) and AUIPC (0010111): inst[31:12] = imm[31:12].
  - JAL (1101111): J-type scramble of imm[20:1].
  - JALR (1100111): I-type.
  - BRANCH (1100011): B-type scramble of imm[12:1].
  - LOAD (0000011): I-type.
  - STORE (0100011): S-type.
  - FENCE (0001111) and SYSTEM (1110011): I-type using the given fields.
- OP (0110011): funct3 and funct7 are derived from `req_alu_op`. funct7 = 0100000 for SUB and SRA; 0000000 otherwise.
- OP_IMM (0010011): funct3 is derived from `req_alu_op`; SUB is illegal. For SLL, SRL and SRA, inst[24:20] = imm[4:0], and inst[31:25] = 0100000 for SRA, 0000000 otherwise.
- Always-illegal requests:
  - `req_kind` 11–15.
  - `req_alu_op` > 9 for OP or OP_IMM.
  - SUB for OP_IMM.
  - `req_funct3` values 010, 011 or 110 for BRANCH.
  - `req_funct3` ≠ 000 for JALR.
- Illegal result: `inst` = 32'h0000_0013 with `inst_err` = 1. The address still advances on transfer.

## Timing
- Latency: one cycle from request acceptance to `inst_valid`.
- Reset values: `inst_valid` = 0, `inst` = 32'h0000_0013, `inst_addr` = `BASE_ADDR`, `inst_err` = 0, address register = `BASE_ADDR`.
- `req_ready` is 1 out of reset.
- Stability: while `inst_valid && !inst_ready`, `inst`, `inst_addr` and `inst_err` hold stable.
- Simultaneous transfer and accept: the new word is loaded in the same cycle, `inst_valid` stays 1, and the new word carries the advanced address.
- Reset mid-operation: a pending word is discarded without transfer and the address returns to `BASE_ADDR`.

## Configuration
- `INST_ENC_RANGE_CHK_EN` defined: immediate range and alignment checking is compiled in. Each failing case sets `inst_err` and emits the NOP:
  - I- and S-type: imm must be the sign extension of imm[11:0].
  - B-type: imm must be the sign extension of imm[12:0] with imm[0] = 0.
  - J-type: imm must be the sign extension of imm[20:0] with imm[0] = 0.
  - U-type: imm[11:0] must be 0.
  - Shift-immediate: imm[31:5] must be 0.
- Not defined: immediates are silently truncated to the encodable bits. `inst_err` reflects only the always-illegal cases.

## Test plan
- Reset, then ADDI x1,x0,5 with `inst_ready` = 1 → next cycle `inst` = 0x00500093, `inst_addr` = 0x8000_0000, `inst_err` = 0.
- Back-to-back ADD x3,x1,x2 then SUB x3,x1,x2 → 0x002081B3 at 0x8000_0000, then 0x402081B3 at 0x8000_0004, with no bubble.
- LUI x5,0x12345000 → 0x123452B7.
- JAL x1,+8 → 0x008000EF.
- BEQ x1,x2,-4 → 0xFE208EE3.
- Backpressure: hold `inst_ready` = 0 and issue two requests → the second request sees `req_ready` = 0 and the first word stays stable. Release `inst_ready` → both words emerge in order at consecutive addresses.
- Errors:
  - ADDI with imm = 2048 under `INST_ENC_RANGE_CHK_EN` → `inst` = 0x00000013, `inst_err` = 1.
  - Same request without the macro → 0x80000093, `inst_err` = 0.
  - `req_kind` = 12 → NOP with `inst_err` = 1 in both builds.
- Reset asserted while `inst_valid` = 1 and `inst_ready` = 0 → `inst_valid` = 0 immediately. After release, the next word is tagged 0x8000_0000.
